// File: rtl/float_to_int.sv
// IEEE-754 single-precision to signed 32-bit integer, truncating toward zero and saturating.
// Multi-cycle stb/ack stream stage; normalisation shifts one bit per cycle.
module float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 10;
  localparam int unsigned MW = 23;
  localparam int unsigned CW = 5;

  localparam logic signed [EW-1:0] E_INF  = 10'sd128;
  localparam logic signed [EW-1:0] E_ZERO = -10'sd127;
  localparam logic signed [EW-1:0] E_SAT  = 10'sd31;
  localparam logic [DW-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    GET_A         = 3'd0,
    UNPACK        = 3'd1,
    SPECIAL_CASES = 3'd2,
    CONVERT       = 3'd3,
    PACK          = 3'd4,
    PUT_Z         = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [DW-1:0]          a, a_nxt;
  logic                   s, s_nxt;
  logic signed [EW-1:0]   e, e_nxt;
  logic [MW-1:0]          m, m_nxt;
  logic [DW-1:0]          r, r_nxt;
  logic [CW-1:0]          c, c_nxt;
  logic [DW-1:0]          z, z_nxt;
  logic                   input_a_ack_nxt;
  logic [DW-1:0]          output_z_nxt;
  logic                   output_z_stb_nxt;

  // Next-state and datapath updates
  always_comb begin
    state_nxt        = state;
    a_nxt            = a;
    s_nxt            = s;
    e_nxt            = e;
    m_nxt            = m;
    r_nxt            = r;
    c_nxt            = c;
    z_nxt            = z;
    input_a_ack_nxt  = input_a_ack;
    output_z_nxt     = output_z;
    output_z_stb_nxt = output_z_stb;

    case (state)
      GET_A: begin
        input_a_ack_nxt = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_nxt           = input_a;
          input_a_ack_nxt = 1'b0;
          state_nxt       = UNPACK;
        end
      end

      UNPACK: begin
        s_nxt     = a[31];
        e_nxt     = $signed(EW'({2'b00, a[30:23]}) - EW'(127));
        m_nxt     = a[22:0];
        state_nxt = SPECIAL_CASES;
      end

      SPECIAL_CASES: begin
        state_nxt = PUT_Z;
        if (e == E_INF) begin
          if (m != '0) z_nxt = INT_MIN;
          else         z_nxt = s ? INT_MIN : INT_MAX;
        end else if (e == E_ZERO) begin
          z_nxt = '0;
        end else if (e < 0) begin
          z_nxt = '0;
        end else if (e >= E_SAT) begin
          z_nxt = s ? INT_MIN : INT_MAX;
        end else begin
          // Implicit one sits at bit 31; shift right until the binary point lines up
          r_nxt     = {1'b1, m, 8'b0};
          c_nxt     = e[CW-1:0];
          state_nxt = CONVERT;
        end
      end

      CONVERT: begin
        if (c == CW'(31)) begin
          state_nxt = PACK;
        end else begin
          r_nxt = r >> 1;
          c_nxt = c + CW'(1);
        end
      end

      PACK: begin
        z_nxt     = s ? (~r + DW'(1)) : r;
        state_nxt = PUT_Z;
      end

      PUT_Z: begin
        output_z_nxt     = z;
        output_z_stb_nxt = 1'b1;
        if (output_z_stb && output_z_ack) begin
          output_z_stb_nxt = 1'b0;
          state_nxt        = GET_A;
        end
      end

      default: state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= GET_A;
      a            <= '0;
      s            <= 1'b0;
      e            <= '0;
      m            <= '0;
      r            <= '0;
      c            <= '0;
      z            <= '0;
      input_a_ack  <= 1'b0;
      output_z     <= '0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_nxt;
      a            <= a_nxt;
      s            <= s_nxt;
      e            <= e_nxt;
      m            <= m_nxt;
      r            <= r_nxt;
      c            <= c_nxt;
      z            <= z_nxt;
      input_a_ack  <= input_a_ack_nxt;
      output_z     <= output_z_nxt;
      output_z_stb <= output_z_stb_nxt;
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed corner values, handshake/reset behaviour
// and randomized operands against an arithmetic reference model.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int total = 0;
  int bad   = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result from the numeric definition: truncate |x| to an integer, saturate, apply sign
  function automatic logic [31:0] ref_val(input logic [31:0] f);
    int     ef;
    int     ex;
    longint mant;
    longint mag;
    ef = int'(f[30:23]);
    ex = ef - 127;
    if (ef == 255) return (f[22:0] != 23'd0 || f[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (ef == 0 || ex < 0) return 32'h0;
    if (ex >= 31) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    mant = longint'({1'b1, f[22:0]});
    mag  = (ex >= 23) ? (mant << (ex - 23)) : (mant >> (23 - ex));
    return f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  function automatic int ref_lat(input logic [31:0] f);
    int ef;
    int ex;
    ef = int'(f[30:23]);
    ex = ef - 127;
    if (ef == 255 || ef == 0 || ex < 0 || ex >= 31) return 3;
    return 36 - ex;
  endfunction

  // Present one operand and complete the input handshake
  task automatic send(input logic [31:0] v);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!input_a_ack && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!input_a_ack) begin
      total++;
      bad++;
      $error("FAIL ack_timeout: observed=0 expected=1");
    end
    input_a     = v;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1 input_a_stb = 1'b0;
  endtask

  // Count edges after the accept edge until output_z_stb is seen
  task automatic wait_result(output logic [31:0] res, output int lat);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      total++;
      bad++;
      $error("FAIL stb_timeout: observed=0 expected=1");
    end
    res = output_z;
  endtask

  task automatic release_z(input string tag);
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    check({tag, "_stb_drop"}, 32'(output_z_stb), 32'd0);
    check({tag, "_ack_low"}, 32'(input_a_ack), 32'd0);
    @(posedge clk);
    #1 check({tag, "_ack_back"}, 32'(input_a_ack), 32'd1);
  endtask

  localparam int unsigned ND = 12;
  logic [31:0] dir_in  [ND];
  logic [31:0] dir_exp [ND];
  int          dir_lat [ND];

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] v;
    int          lat;

    dir_in  = '{32'h3F80_0000, 32'h47F1_2000, 32'hC020_0000, 32'h3F40_0000,
                32'h8000_0000, 32'h0000_0001, 32'h4F00_0000, 32'hCF00_0000,
                32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h4EFF_FFFF};
    dir_exp = '{32'h0000_0001, 32'h0001_E240, 32'hFFFF_FFFE, 32'h0000_0000,
                32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FF80};
    dir_lat = '{36, 20, 35, 3, 3, 3, 3, 3, 3, 3, 3, 6};

    rst          = 1'b0;
    input_a      = 32'h0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(input_a_ack), 32'd0);
    check("rst_stb", 32'(output_z_stb), 32'd0);
    check("rst_z", output_z, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("rst_ack_rise", 32'(input_a_ack), 32'd1);

    // Directed corner values
    for (int i = 0; i < int'(ND); i++) begin
      send(dir_in[i]);
      wait_result(res, lat);
      check($sformatf("dir%0d_val", i), res, dir_exp[i]);
      check($sformatf("dir%0d_lat", i), 32'(lat), 32'(dir_lat[i]));
      release_z($sformatf("dir%0d", i));
    end

    // Backpressure with a competing operand offered during put_z
    send(32'h47F1_2000);
    wait_result(res, lat);
    held = res;
    check("bp_val", res, 32'h0001_E240);
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_stb%0d", k), 32'(output_z_stb), 32'd1);
      check($sformatf("bp_z%0d", k), output_z, held);
      check($sformatf("bp_inack%0d", k), 32'(input_a_ack), 32'd0);
    end
    input_a_stb = 1'b0;
    release_z("bp");

    // Reset in the middle of a conversion, then a fresh operand
    send(32'h3F80_0000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_stb", 32'(output_z_stb), 32'd0);
    check("mid_rst_ack", 32'(input_a_ack), 32'd0);
    check("mid_rst_z", output_z, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_ack_rise", 32'(input_a_ack), 32'd1);
    send(32'h4040_0000);
    wait_result(res, lat);
    check("post_rst_val", res, 32'h0000_0003);
    check("post_rst_lat", 32'(lat), 32'd35);
    release_z("post_rst");

    // Randomized operands, mostly with exponents near the conversion range
    for (int i = 0; i < 60; i++) begin
      v = $urandom;
      if ($urandom_range(3, 0) != 0) v[30:23] = 8'($urandom_range(160, 115));
      send(v);
      wait_result(res, lat);
      check($sformatf("rnd%0d_val_%h", i, v), res, ref_val(v));
      check($sformatf("rnd%0d_lat_%h", i, v), 32'(lat), 32'(ref_lat(v)));
      release_z($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Converts an IEEE-754 single-precision value into a signed 32-bit two's-complement integer, rounding toward zero and saturating on overflow. It sits directly downstream of the floating-point divider and consumes its `output_z`/`output_z_stb`/`output_z_ack` stream on `input_a`. It uses the same stb/ack handshake and multi-cycle state-machine style as the divider. Normalisation uses a one-bit-per-cycle shifter, so latency depends on the exponent.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low; priority over all other logic.
- input_a  in  32  single-precision operand.
- input_a_stb  in  1  operand valid.
- input_a_ack  out  1  block ready to accept operand.
- output_z  out  32  signed integer result.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accepts result.

## Operation
- States: get_a(0), unpack(1), special_cases(2), convert(3), pack(4), put_z(5).
- **get_a**
  - Drive input_a_ack=1.
  - On an edge with input_a_ack && input_a_stb:
    - Latch input_a.
    - Drop ack.
    - Go to unpack.
- **unpack**
  - Latch the fields: s=a[31], e=a[30:23]-127 (10-bit signed), m=a[22:0].
  - Go to special_cases.
- **special_cases** (first match wins; every case except the last loads z and goes to put_z):
  - Exponent field 255, m≠0 (NaN): z=0x80000000.
  - Exponent field 255, m=0 (±inf): z=0x7FFFFFFF if s=0, else 0x80000000.
  - Exponent field 0 (zero or denormal): z=0.
  - e<0 (magnitude <1): z=0.
  - e≥31: z=0x7FFFFFFF if s=0, else 0x80000000.
  - Otherwise:
    - Load 32-bit register r={1,m,8'b0}; the implicit one is at bit 31.
    - Load counter c=e.
    - Go to convert.
- **convert**
  - If c==31, go to pack.
  - Otherwise, r<=r>>1 and c<=c+1.
  - Exactly 31−e shift cycles; discarded bits are truncated.
- **pack**
  - z = s ? (~r+1) : r.
  - r≤0x7FFFFFFF is guaranteed here, since e≤30.
  - Go to put_z.
- **put_z**
  - Drive output_z<=z and output_z_stb<=1.
  - On an edge with output_z_stb && output_z_ack:
    - Drop stb.
    - Go to get_a.
- -0.0 returns 0.
- Exact −2^31 (0xCF000000) returns 0x80000000 via the e≥31 rule.

## Timing
- **Reset** (rst=0 at a rising edge):
  - state=get_a.
  - input_a_ack=0, output_z_stb=0, output_z=0.
  - input_a_ack rises on the first edge with rst=1.
- **Handshakes**
  - A transfer occurs only on an edge where the block's own ack (input) or stb (output) is already high together with the partner signal.
  - input_a is ignored outside get_a.
- **Latency**, counting edges from the input-accept edge to the edge that raises output_z_stb:
  - Normal path: 5 + (31−e).
  - Maximum: 36 (e=0).
  - Minimum: 6 (e=30).
  - Special cases: 3.
- **Backpressure**
  - With output_z_ack low, output_z_stb and output_z hold indefinitely and stay stable.
  - No new operand is accepted.
- **Turnaround**
  - input_a_ack re-asserts one edge after the output-accept edge.
  - Throughput is one result per conversion; there is no overlap.
- **Reset mid-operation**
  - Reset from any state aborts the conversion.
  - No output_z_stb pulse is produced for the aborted operand.
- **Simultaneous events**
  - input_a_stb held high during put_z has no effect.
  - rst=0 coinciding with a handshake edge: reset wins and no transfer is recorded.

## Test plan
- 0x3F800000 (1.0) -> 0x00000001, output_z_stb 36 edges after accept; 0x47F12000 (123456.0) -> 0x0001E240, latency 20.
- 0xC0200000 (−2.5) -> 0xFFFFFFFE; 0x3F400000 (0.75) -> 0; 0x80000000 (−0.0) -> 0; 0x00000001 (denormal) -> 0, latency 3.
- 0x4F000000 (2^31) -> 0x7FFFFFFF; 0xCF000000 -> 0x80000000; 0x7F800000 -> 0x7FFFFFFF; 0xFF800000 -> 0x80000000; 0x7FC00000 (NaN) -> 0x80000000; all latency 3.
- 0x4EFFFFFF (2147483520.0) -> 0x7FFFFF80, latency 6 (e=30 boundary).
- Hold output_z_ack low for 10 cycles after output_z_stb rises -> stb and data stable; ack high -> stb drops next edge, input_a_ack high one edge later.
- Assert rst=0 for one edge during convert of 1.0 -> stb=0, ack=0, output_z=0; next operand 0x40400000 (3.0) -> 0x00000003, with no stale result emitted.
